// File: rtl/vx_socket_mem_arb_if.sv
// Memory request/response bus bundle shared by the socket side (NUM_PORTS lanes)
// and the merged cluster side (one lane). Per-lane fields are packed flat, lane 0 in the LSBs.
// Response data and tag are a single shared lane; response valid/ready are per lane.
interface vx_socket_mem_arb_if #(
    parameter int unsigned NUM_PORTS  = 1,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned TAG_WIDTH  = 8
);
    logic [NUM_PORTS-1:0]                req_valid;
    logic [NUM_PORTS-1:0]                req_rw;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]     req_data;
    logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byteen;
    logic [NUM_PORTS*TAG_WIDTH-1:0]      req_tag;
    logic [NUM_PORTS-1:0]                req_ready;

    logic [NUM_PORTS-1:0]                rsp_valid;
    logic [DATA_WIDTH-1:0]               rsp_data;
    logic [TAG_WIDTH-1:0]                rsp_tag;
    logic [NUM_PORTS-1:0]                rsp_ready;

    // Requester side: issues requests, consumes responses
    modport master (
        output req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready
    );

    // Responder side: accepts requests, returns responses
    modport slave (
        input  req_valid, req_rw, req_addr, req_data, req_byteen, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/vx_socket_mem_arb.sv
// Cluster memory arbiter: merges NUM_INPUTS socket memory ports into one port.
// Requests are granted round-robin into a 2-entry skid buffer and tagged with the
// source index in the tag LSBs; responses are routed back by that index through a
// 2-entry buffer. Define SOCKET_MEM_ARB_PERF_EN to add the performance counters.
module vx_socket_mem_arb #(
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned TAG_IN_WIDTH = 8,
    localparam int unsigned LOG_N         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
    localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_N
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_socket_mem_arb_if.slave   in_bus,
    vx_socket_mem_arb_if.master  out_bus,
    output logic                 rsp_err
`ifdef SOCKET_MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_req_count,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_rsp_count
`endif
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SEL_W    = (LOG_N > 0) ? LOG_N : 1;
    localparam int unsigned REQ_W    = 1 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH + TAG_OUT_WIDTH;
    localparam int unsigned RSP_W    = DATA_WIDTH + TAG_IN_WIDTH + SEL_W;

    // ---------------------------------------------------------------- common
    logic active_q;

    // Low through reset and until the first edge after release; gates every ready output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) active_q <= 1'b0;
        else        active_q <= 1'b1;
    end

    // ---------------------------------------------------------------- request path
    logic [SEL_W-1:0]          rr_q, rr_d, grant_idx;
    logic                      found, grant, req_space, req_pop;
    logic [1:0]                req_cnt_q;
    logic                      req_rd_q, req_wr_q;
    logic [REQ_W-1:0]          req_mem_q [2];
    logic [REQ_W-1:0]          req_entry;
    logic [2*NUM_INPUTS-1:0]   valid_dbl;
    logic [NUM_INPUTS-1:0]     valid_rot;
    logic                      sel_rw;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [BE_WIDTH-1:0]       sel_be;
    logic [TAG_IN_WIDTH-1:0]   sel_tag;
    logic [TAG_OUT_WIDTH-1:0]  req_tag_out;

    assign valid_dbl = {in_bus.req_valid, in_bus.req_valid} >> rr_q;
    assign valid_rot = valid_dbl[NUM_INPUTS-1:0];
    // A full buffer may still take a grant in the same cycle it drains
    assign req_space = (req_cnt_q != 2'd2) || out_bus.req_ready[0];
    assign grant     = active_q && found && req_space;
    assign req_pop   = (req_cnt_q != 2'd0) && out_bus.req_ready[0];

    // Pick the first valid input at or after rr, and the pointer value following it
    always_comb begin
        int unsigned pos;
        found     = 1'b0;
        grant_idx = '0;
        pos       = 0;
        for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
            if (!found && valid_rot[j]) begin
                found = 1'b1;
                pos   = 32'(rr_q) + j;
                if (pos >= NUM_INPUTS) pos = pos - NUM_INPUTS;
                grant_idx = pos[SEL_W-1:0];
            end
        end
        pos = 32'(grant_idx) + 1;
        if (pos >= NUM_INPUTS) pos = 0;
        rr_d = grant ? pos[SEL_W-1:0] : rr_q;
    end

    // Mux the granted input's fields and drive the one-hot accept
    always_comb begin
        sel_rw           = 1'b0;
        sel_addr         = '0;
        sel_data         = '0;
        sel_be           = '0;
        sel_tag          = '0;
        in_bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_rw              = in_bus.req_rw[i];
                sel_addr            = in_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data            = in_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_be              = in_bus.req_byteen[i*BE_WIDTH +: BE_WIDTH];
                sel_tag             = in_bus.req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
                in_bus.req_ready[i] = grant;
            end
        end
    end

    if (LOG_N > 0) begin : g_req_tag_idx
        assign req_tag_out = {sel_tag, grant_idx[LOG_N-1:0]};
    end else begin : g_req_tag_pass
        assign req_tag_out = sel_tag;
    end

    assign req_entry = {sel_rw, sel_addr, sel_data, sel_be, req_tag_out};

    // Arbitration pointer and request buffer occupancy/pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q      <= '0;
            req_cnt_q <= 2'd0;
            req_rd_q  <= 1'b0;
            req_wr_q  <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            req_cnt_q <= req_cnt_q + {1'b0, grant} - {1'b0, req_pop};
            if (grant)   req_wr_q <= ~req_wr_q;
            if (req_pop) req_rd_q <= ~req_rd_q;
        end
    end

    // Request buffer storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (grant) req_mem_q[req_wr_q] <= req_entry;
    end

    assign out_bus.req_valid[0] = (req_cnt_q != 2'd0);
    assign {out_bus.req_rw, out_bus.req_addr, out_bus.req_data, out_bus.req_byteen,
            out_bus.req_tag} = req_mem_q[req_rd_q];

    // ---------------------------------------------------------------- response path
    logic [SEL_W-1:0]         rsp_sel, head_sel;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_in;
    logic                     sel_ok, rsp_fire, rsp_push, rsp_pop, rsp_err_q;
    logic [1:0]               rsp_cnt_q;
    logic                     rsp_rd_q, rsp_wr_q;
    logic [RSP_W-1:0]         rsp_mem_q [2];

    if (LOG_N > 0) begin : g_rsp_tag_idx
        assign rsp_sel    = out_bus.rsp_tag[LOG_N-1:0];
        assign rsp_tag_in = out_bus.rsp_tag[TAG_OUT_WIDTH-1:LOG_N];
    end else begin : g_rsp_tag_pass
        assign rsp_sel    = '0;
        assign rsp_tag_in = out_bus.rsp_tag;
    end

    assign sel_ok               = (32'(rsp_sel) < NUM_INPUTS);
    assign out_bus.rsp_ready[0] = active_q && (rsp_cnt_q != 2'd2);
    assign rsp_fire             = out_bus.rsp_valid[0] && out_bus.rsp_ready[0];
    // Responses addressed to a nonexistent input are consumed but never stored
    assign rsp_push             = rsp_fire && sel_ok;
    assign rsp_pop              = |(in_bus.rsp_valid & in_bus.rsp_ready);
    assign rsp_err              = rsp_err_q;

    assign {in_bus.rsp_data, in_bus.rsp_tag, head_sel} = rsp_mem_q[rsp_rd_q];

    // Present the head response only on the input it belongs to
    always_comb begin
        in_bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            in_bus.rsp_valid[i] = (rsp_cnt_q != 2'd0) && (head_sel == SEL_W'(i));
        end
    end

    // Response buffer occupancy/pointers and the sticky bad-index flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_cnt_q <= 2'd0;
            rsp_rd_q  <= 1'b0;
            rsp_wr_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_cnt_q <= rsp_cnt_q + {1'b0, rsp_push} - {1'b0, rsp_pop};
            if (rsp_push)            rsp_wr_q  <= ~rsp_wr_q;
            if (rsp_pop)             rsp_rd_q  <= ~rsp_rd_q;
            if (rsp_fire && !sel_ok) rsp_err_q <= 1'b1;
        end
    end

    // Response buffer storage
    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem_q[rsp_wr_q] <= {out_bus.rsp_data, rsp_tag_in, rsp_sel};
    end

`ifdef SOCKET_MEM_ARB_PERF_EN
    // Event counters; wrap at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_req_count    <= '0;
            perf_stall_cycles <= '0;
            perf_rsp_count    <= '0;
        end else begin
            if (grant)                          perf_req_count    <= perf_req_count + 32'd1;
            if ((|in_bus.req_valid) && !grant)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (rsp_pop)                        perf_rsp_count    <= perf_rsp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_socket_mem_arb.sv
// Self-checking bench for vx_socket_mem_arb: a 4-input instance checked every cycle
// against a queue-based reference model, plus a 3-input instance for bad-index responses.
module tb_vx_socket_mem_arb;
    localparam int N   = 4;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int TOW = 10;
    localparam int BW  = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    vx_socket_mem_arb_if #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) in4 ();
    vx_socket_mem_arb_if #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TOW)) out4 ();
    vx_socket_mem_arb_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) in3 ();
    vx_socket_mem_arb_if #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TOW)) out3 ();

    logic rsp_err4, rsp_err3;
`ifdef SOCKET_MEM_ARB_PERF_EN
    logic [31:0] p4_req, p4_stall, p4_rsp, p3_req, p3_stall, p3_rsp;
`endif

    vx_socket_mem_arb #(.NUM_INPUTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .in_bus  (in4),
        .out_bus (out4),
        .rsp_err (rsp_err4)
`ifdef SOCKET_MEM_ARB_PERF_EN
        ,
        .perf_req_count    (p4_req),
        .perf_stall_cycles (p4_stall),
        .perf_rsp_count    (p4_rsp)
`endif
    );

    vx_socket_mem_arb #(.NUM_INPUTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .in_bus  (in3),
        .out_bus (out3),
        .rsp_err (rsp_err3)
`ifdef SOCKET_MEM_ARB_PERF_EN
        ,
        .perf_req_count    (p3_req),
        .perf_stall_cycles (p3_stall),
        .perf_rsp_count    (p3_rsp)
`endif
    );

    typedef struct packed {
        logic           rw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BW-1:0]  be;
        logic [TOW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   rr_m = 0;
    int   last_grant = -1;

    task automatic model_clear();
        req_q.delete();
        rsp_q.delete();
        rr_m = 0;
    endtask

    task automatic idle_inputs();
        in4.req_valid  = '0;
        in4.req_rw     = '0;
        in4.req_addr   = '0;
        in4.req_data   = '0;
        in4.req_byteen = '0;
        in4.req_tag    = '0;
        in4.rsp_ready  = 4'hF;
        out4.req_ready = 1'b1;
        out4.rsp_valid = 1'b0;
        out4.rsp_data  = '0;
        out4.rsp_tag   = '0;
        in3.req_valid  = '0;
        in3.req_rw     = '0;
        in3.req_addr   = '0;
        in3.req_data   = '0;
        in3.req_byteen = '0;
        in3.req_tag    = '0;
        in3.rsp_ready  = 3'h7;
        out3.req_ready = 1'b1;
        out3.rsp_valid = 1'b0;
        out3.rsp_data  = '0;
        out3.rsp_tag   = '0;
    endtask

    task automatic rand_req_fields();
        in4.req_rw = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            in4.req_addr[i*AW +: AW]   = AW'($urandom);
            in4.req_data[i*DW +: DW]   = $urandom;
            in4.req_byteen[i*BW +: BW] = BW'($urandom);
            in4.req_tag[i*TW +: TW]    = TW'($urandom);
        end
    endtask

    // One clock of dut4: check outputs mid-cycle against the model, then advance the model
    task automatic cycle();
        int   exp_g;
        logic can, exp_rrdy;
        logic [3:0] exp_ready, exp_rvalid;
        req_t act, e;
        rsp_t r;
        @(negedge clk);
        can   = (req_q.size() < 2) || out4.req_ready[0];
        exp_g = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                int idx = (rr_m + k) % N;
                if (exp_g < 0 && in4.req_valid[idx]) exp_g = idx;
            end
        end
        exp_ready = (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000;
        n_checks++;
        if (in4.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_req_ready: got %b expected %b", in4.req_ready, exp_ready);
        end
        n_checks++;
        if (out4.req_valid[0] !== (req_q.size() > 0)) begin
            n_fail++;
            $display("FAIL out_req_valid: got %b expected %0d", out4.req_valid, req_q.size() > 0);
        end
        if (req_q.size() > 0) begin
            act = {out4.req_rw[0], out4.req_addr, out4.req_data, out4.req_byteen, out4.req_tag};
            n_checks++;
            if (act !== req_q[0]) begin
                n_fail++;
                $display("FAIL out_req fields: got %h expected %h", act, req_q[0]);
            end
        end
        exp_rrdy = (rsp_q.size() < 2);
        n_checks++;
        if (out4.rsp_ready[0] !== exp_rrdy) begin
            n_fail++;
            $display("FAIL out_rsp_ready: got %b expected %b", out4.rsp_ready, exp_rrdy);
        end
        exp_rvalid = (rsp_q.size() > 0) ? (4'b0001 << rsp_q[0].sel) : 4'b0000;
        n_checks++;
        if (in4.rsp_valid !== exp_rvalid) begin
            n_fail++;
            $display("FAIL in_rsp_valid: got %b expected %b", in4.rsp_valid, exp_rvalid);
        end
        if (rsp_q.size() > 0) begin
            n_checks++;
            if (in4.rsp_tag !== rsp_q[0].tag || in4.rsp_data !== rsp_q[0].data) begin
                n_fail++;
                $display("FAIL in_rsp tag/data: got %h/%h expected %h/%h",
                         in4.rsp_tag, in4.rsp_data, rsp_q[0].tag, rsp_q[0].data);
            end
        end
        last_grant = exp_g;
        @(posedge clk);
        if (req_q.size() > 0 && out4.req_ready[0]) void'(req_q.pop_front());
        if (exp_g >= 0) begin
            e.rw   = in4.req_rw[exp_g];
            e.addr = in4.req_addr[exp_g*AW +: AW];
            e.data = in4.req_data[exp_g*DW +: DW];
            e.be   = in4.req_byteen[exp_g*BW +: BW];
            e.tag  = {in4.req_tag[exp_g*TW +: TW], 2'(exp_g)};
            req_q.push_back(e);
            rr_m = (exp_g + 1) % N;
        end
        if (rsp_q.size() > 0 && in4.rsp_ready[rsp_q[0].sel]) void'(rsp_q.pop_front());
        if (out4.rsp_valid[0] && exp_rrdy) begin
            r.sel  = out4.rsp_tag[1:0];
            r.tag  = out4.rsp_tag[TOW-1:2];
            r.data = out4.rsp_data;
            rsp_q.push_back(r);
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in4.req_valid = 4'hF;
        in3.req_valid = 3'h7;
        #1;
        n_checks++;
        if (in4.req_ready !== 4'h0 || in3.req_ready !== 3'h0) begin
            n_fail++;
            $display("FAIL reset in_req_ready: got %b/%b expected 0", in4.req_ready, in3.req_ready);
        end
        n_checks++;
        if (out4.req_valid !== 1'b0 || in4.rsp_valid !== 4'h0 || out4.rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valids: got %b %b %b expected 0 0 0",
                     out4.req_valid, in4.rsp_valid, out4.rsp_ready);
        end
        n_checks++;
        if (rsp_err4 !== 1'b0 || rsp_err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset rsp_err: got %b/%b expected 0", rsp_err4, rsp_err3);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out4.rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL out_rsp_ready before first edge: got %b expected 0", out4.rsp_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out4.rsp_ready !== 1'b1 || out3.rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL out_rsp_ready after edge: got %b/%b expected 1", out4.rsp_ready,
                     out3.rsp_ready);
        end
        model_clear();
    endtask

    task automatic test_round_robin();
        in4.req_valid  = 4'hF;
        out4.req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rand_req_fields();
            cycle();
            n_checks++;
            if (last_grant !== k % 4) begin
                n_fail++;
                $display("FAIL rr order: got %0d expected %0d", last_grant, k % 4);
            end
        end
    endtask

    task automatic test_single();
        in4.req_valid           = 4'b0100;
        in4.req_tag[2*TW +: TW] = 8'h5A;
        in4.req_addr[2*AW +: AW] = 26'h123;
        cycle();
        in4.req_valid = 4'b0000;
        n_checks++;
        if (out4.req_tag !== 10'h16A || out4.req_addr !== 26'h123 || out4.req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single tag/addr: got %h/%h expected 16a/123", out4.req_tag,
                     out4.req_addr);
        end
        in4.req_valid = 4'hF;
        cycle();
        n_checks++;
        if (last_grant !== 3) begin
            n_fail++;
            $display("FAIL rr after single: got %0d expected 3", last_grant);
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        in4.req_valid = 4'h0;
        repeat (2) cycle();
        in4.req_valid  = 4'hF;
        out4.req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_req_fields();
            cycle();
            if (last_grant >= 0) grants++;
        end
        n_checks++;
        if (grants !== 2 || in4.req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL backpressure: got %0d grants ready %b expected 2 grants ready 0",
                     grants, in4.req_ready);
        end
        in4.req_valid  = 4'h0;
        out4.req_ready = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (out4.req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got out_req_valid %b expected 0", out4.req_valid);
        end
    endtask

    task automatic test_rsp_directed();
        in4.rsp_ready  = 4'b1011;
        out4.rsp_valid = 1'b1;
        out4.rsp_tag   = 10'h16A;
        out4.rsp_data  = $urandom;
        cycle();
        out4.rsp_tag   = 10'h041;
        out4.rsp_data  = $urandom;
        cycle();
        out4.rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in4.rsp_valid !== 4'b0100 || in4.rsp_tag !== 8'h5A) begin
                n_fail++;
                $display("FAIL rsp held: got %b/%h expected 0100/5a", in4.rsp_valid, in4.rsp_tag);
            end
            cycle();
        end
        in4.rsp_ready = 4'hF;
        cycle();
        n_checks++;
        if (in4.rsp_valid !== 4'b0010 || in4.rsp_tag !== 8'h10) begin
            n_fail++;
            $display("FAIL rsp second: got %b/%h expected 0010/10", in4.rsp_valid, in4.rsp_tag);
        end
        cycle();
        n_checks++;
        if (in4.rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rsp empty: got %b expected 0000", in4.rsp_valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in4.req_valid  = 4'($urandom);
            rand_req_fields();
            out4.req_ready = ($urandom % 4) != 0;
            out4.rsp_valid = 1'($urandom);
            out4.rsp_tag   = TOW'($urandom);
            out4.rsp_data  = $urandom;
            in4.rsp_ready  = 4'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();
    endtask

    task automatic test_err();
        out3.rsp_valid = 1'b1;
        out3.rsp_tag   = {8'hAB, 2'd3};
        out3.rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (out3.rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err accept: got out_rsp_ready %b expected 1", out3.rsp_ready);
        end
        @(posedge clk);
        #1;
        out3.rsp_valid = 1'b0;
        n_checks++;
        if (in3.rsp_valid !== 3'b000 || rsp_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL err drop: got valid %b err %b expected 000 1", in3.rsp_valid, rsp_err3);
        end
        out3.rsp_valid = 1'b1;
        out3.rsp_tag   = {8'h22, 2'd1};
        @(posedge clk);
        #1;
        out3.rsp_valid = 1'b0;
        n_checks++;
        if (in3.rsp_valid !== 3'b010 || in3.rsp_tag !== 8'h22) begin
            n_fail++;
            $display("FAIL err follow-up: got %b/%h expected 010/22", in3.rsp_valid, in3.rsp_tag);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_err3 !== 1'b1 || in3.rsp_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL err sticky: got err %b valid %b expected 1 000", rsp_err3,
                     in3.rsp_valid);
        end
    endtask

    task automatic test_reset_midflight();
        in4.req_valid  = 4'hF;
        out4.req_ready = 1'b0;
        in4.rsp_ready  = 4'h0;
        out4.rsp_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_req_fields();
            out4.rsp_tag  = TOW'($urandom);
            out4.rsp_data = $urandom;
            cycle();
        end
        out4.rsp_valid = 1'b0;
        n_checks++;
        if (out4.req_valid !== 1'b1 || out4.rsp_ready !== 1'b0 || in4.rsp_valid === 4'h0) begin
            n_fail++;
            $display("FAIL fill: got req_valid %b rsp_ready %b rsp_valid %b", out4.req_valid,
                     out4.rsp_ready, in4.rsp_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out4.req_valid !== 1'b0 || in4.req_ready !== 4'h0 || in4.rsp_valid !== 4'h0
            || out4.rsp_ready !== 1'b0 || rsp_err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight reset: got %b %b %b %b err %b expected all 0",
                     out4.req_valid, in4.req_ready, in4.rsp_valid, out4.rsp_ready, rsp_err3);
        end
        idle_inputs();
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        in4.req_valid = 4'hF;
        rand_req_fields();
        cycle();
        n_checks++;
        if (last_grant !== 0) begin
            n_fail++;
            $display("FAIL rr after reset: got %0d expected 0", last_grant);
        end
        idle_inputs();
        repeat (2) cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_rsp_directed();
        test_random();
        test_err();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
